// File: rtl/mem_data_sized.sv
// mem_data_sized: byte/halfword/word data memory for the single-cycle core.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   ADDR_BASE    byte address of word 0 (aligned to DEPTH_WORDS*4)
//   INIT_CLEAR   1 = zero the array one word per cycle after reset
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_mem_write/read   store / load request
//   i_funct3           access type (B, H, W, BU, HU)
//   i_mem_addr         byte address
//   i_mem_data         store data (low byte/half used for B/H)
//   o_mem_data         combinational load data, extended per funct3
//   o_busy             clear sequence in progress
//   o_misaligned       misaligned access or illegal funct3
//   o_range_err        address outside the mapped window
//   o_err_sticky       set by any faulting request, cleared by reset
module mem_data_sized #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter bit          INIT_CLEAR  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_write,
    input  logic        i_mem_read,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_data,
    output logic [31:0] o_mem_data,
    output logic        o_busy,
    output logic        o_misaligned,
    output logic        o_range_err,
    output logic        o_err_sticky
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic {StClear, StRun} state_e;

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            sticky_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [31:0]     off;
    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic            legal;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [31:0]     rword;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;
    logic            unused_off;

    // Wrap-around below ADDR_BASE yields a huge offset, so one unsigned compare covers both ends.
    assign off         = i_mem_addr - ADDR_BASE;
    assign word_idx    = off[AW+1:2];
    assign lane        = off[1:0];
    assign unused_off  = ^off[31:AW+2];
    assign o_range_err = (off >= SPAN);
    assign o_busy      = (state_q == StClear);
    assign legal       = ~o_misaligned & ~o_range_err & ~o_busy;
    assign o_err_sticky = sticky_q;

    always_comb begin
        case (i_funct3)
            3'b000, 3'b100: o_misaligned = 1'b0;
            3'b001, 3'b101: o_misaligned = lane[0];
            3'b010:         o_misaligned = (lane != 2'b00);
            default:        o_misaligned = 1'b1;
        endcase
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        be    = 4'b0000;
        wdata = i_mem_data;
        case (i_funct3)
            3'b000: begin
                be    = 4'b0001 << lane;
                wdata = {4{i_mem_data[7:0]}};
            end
            3'b001: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_mem_data[15:0]}};
            end
            3'b010: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Combinational little-endian load path.
    always_comb begin
        rword = mem_q[word_idx];
        rbyte = 8'(rword >> {lane, 3'b000});
        rhalf = lane[1] ? rword[31:16] : rword[15:0];
        o_mem_data = '0;
        if (legal) begin
            case (i_funct3)
                3'b000:  o_mem_data = {{24{rbyte[7]}}, rbyte};
                3'b001:  o_mem_data = {{16{rhalf[15]}}, rhalf};
                3'b010:  o_mem_data = rword;
                3'b100:  o_mem_data = {24'h0, rbyte};
                3'b101:  o_mem_data = {16'h0, rhalf};
                default: o_mem_data = '0;
            endcase
        end
    end

    // Control FSM: clear sequencer, counter and sticky error flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= INIT_CLEAR ? StClear : StRun;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            case (state_q)
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
                        state_q <= StRun;
                    end
                end
                default: begin
                    if ((i_mem_write | i_mem_read) & (o_misaligned | o_range_err)) begin
                        sticky_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Array: no reset, so contents survive reset when INIT_CLEAR=0.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state_q == StClear) begin
                mem_q[cnt_q] <= '0;
            end else if (i_mem_write & legal) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_data_sized.sv
module tb_mem_data_sized;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        misaligned;
    logic        range_err;
    logic        err_sticky;

    int passed = 0;
    int total  = 0;

    mem_data_sized #(
        .DEPTH_WORDS(128),
        .ADDR_BASE  (32'h0000_0000),
        .INIT_CLEAR (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_write (mem_write),
        .i_mem_read  (mem_read),
        .i_funct3    (funct3),
        .i_mem_addr  (mem_addr),
        .i_mem_data  (mem_wdata),
        .o_mem_data  (mem_rdata),
        .o_busy      (busy),
        .o_misaligned(misaligned),
        .o_range_err (range_err),
        .o_err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_write = 1'b0;
        mem_read  = 1'b0;
        funct3    = 3'b010;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1;
        mem_read  = 1'b0;
        funct3    = f3;
        mem_addr  = a;
        mem_wdata = d;
        step();
        idle();
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a);
        mem_write = 1'b0;
        mem_read  = 1'b1;
        funct3    = f3;
        mem_addr  = a;
        #1;
    endtask

    task automatic count_clear(input string name);
        int n = 0;
        while (busy && n < 1000) begin
            step();
            n++;
        end
        total++;
        if (n !== 128) $display("FAIL %s: busy cycles %0d, want 128", name, n);
        else passed++;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        load(3'b010, 32'h0);
        total++;
        if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy);
        else passed++;
        total++;
        if (err_sticky !== 1'b0) $display("FAIL reset_sticky: got %b want 0", err_sticky);
        else passed++;
        total++;
        if (mem_rdata !== 32'h0) $display("FAIL reset_data: got %h want 0", mem_rdata);
        else passed++;
        idle();
        rst = 1'b0;
    endtask

    task automatic test_clear();
        int n = 0;
        int bad = 0;
        // Aligned SW issued while busy must be dropped; misaligned one must not set sticky.
        mem_write = 1'b1;
        funct3    = 3'b010;
        mem_addr  = 32'h10;
        mem_wdata = 32'hdead_beef;
        while (busy && n < 1000) begin
            step();
            n++;
            if (n == 2) mem_addr = 32'h12;
            if (n == 4) idle();
        end
        idle();
        total++;
        if (n !== 128) $display("FAIL clear_latency: busy cycles %0d, want 128", n);
        else passed++;
        for (int i = 0; i < 128; i++) begin
            load(3'b010, 32'(i * 4));
            if (mem_rdata !== 32'h0) bad++;
        end
        idle();
        total++;
        if (bad !== 0) $display("FAIL clear_zero: nonzero words %0d, want 0", bad);
        else passed++;
        total++;
        if (err_sticky !== 1'b0) $display("FAIL clear_sticky: got %b want 0", err_sticky);
        else passed++;
    endtask

    task automatic test_word();
        store(3'b010, 32'h08, 32'hfefe_efef);
        load(3'b010, 32'h08);
        total++;
        if (mem_rdata !== 32'hfefe_efef) $display("FAIL lw_08: got %h want fefeefef", mem_rdata);
        else passed++;
        load(3'b010, 32'h04);
        total++;
        if (mem_rdata !== 32'h0) $display("FAIL lw_04: got %h want 0", mem_rdata);
        else passed++;
        load(3'b010, 32'h0C);
        total++;
        if (mem_rdata !== 32'h0) $display("FAIL lw_0c: got %h want 0", mem_rdata);
        else passed++;
    endtask

    task automatic test_back_to_back();
        // Same-cycle load and store: old data before the edge, new data after.
        mem_write = 1'b1;
        mem_read  = 1'b1;
        funct3    = 3'b010;
        mem_addr  = 32'h08;
        mem_wdata = 32'h1234_5678;
        #1;
        total++;
        if (mem_rdata !== 32'hfefe_efef) $display("FAIL rw_old: got %h want fefeefef", mem_rdata);
        else passed++;
        step();
        mem_write = 1'b0;
        #1;
        total++;
        if (mem_rdata !== 32'h1234_5678) $display("FAIL rw_new: got %h want 12345678", mem_rdata);
        else passed++;
        idle();
    endtask

    task automatic test_byte();
        store(3'b010, 32'h08, 32'h1111_1111);
        store(3'b000, 32'h09, 32'haaaa_aa80);
        load(3'b010, 32'h08);
        total++;
        if (mem_rdata !== 32'h1111_8011) $display("FAIL sb_word: got %h want 11118011", mem_rdata);
        else passed++;
        load(3'b000, 32'h09);
        total++;
        if (mem_rdata !== 32'hffff_ff80) $display("FAIL lb_09: got %h want ffffff80", mem_rdata);
        else passed++;
        load(3'b100, 32'h09);
        total++;
        if (mem_rdata !== 32'h0000_0080) $display("FAIL lbu_09: got %h want 00000080", mem_rdata);
        else passed++;
        load(3'b000, 32'h0B);
        total++;
        if (mem_rdata !== 32'h0000_0011) $display("FAIL lb_0b: got %h want 00000011", mem_rdata);
        else passed++;
        idle();
    endtask

    task automatic test_half();
        store(3'b010, 32'h0C, 32'h5555_3333);
        store(3'b001, 32'h0E, 32'hbeef_8001);
        load(3'b001, 32'h0E);
        total++;
        if (mem_rdata !== 32'hffff_8001) $display("FAIL lh_0e: got %h want ffff8001", mem_rdata);
        else passed++;
        load(3'b101, 32'h0E);
        total++;
        if (mem_rdata !== 32'h0000_8001) $display("FAIL lhu_0e: got %h want 00008001", mem_rdata);
        else passed++;
        load(3'b010, 32'h0C);
        total++;
        if (mem_rdata !== 32'h8001_3333) $display("FAIL sh_word: got %h want 80013333", mem_rdata);
        else passed++;
        load(3'b001, 32'h0C);
        total++;
        if (mem_rdata !== 32'h0000_3333) $display("FAIL lh_0c: got %h want 00003333", mem_rdata);
        else passed++;
        idle();
    endtask

    task automatic test_faults();
        #1;
        total++;
        if (err_sticky !== 1'b0) $display("FAIL sticky_pre: got %b want 0", err_sticky);
        else passed++;
        mem_write = 1'b1;
        funct3    = 3'b010;
        mem_addr  = 32'h0A;
        mem_wdata = 32'h9999_9999;
        #1;
        total++;
        if (misaligned !== 1'b1) $display("FAIL sw_0a_mis: got %b want 1", misaligned);
        else passed++;
        step();
        idle();
        #1;
        total++;
        if (err_sticky !== 1'b1) $display("FAIL sticky_set: got %b want 1", err_sticky);
        else passed++;
        load(3'b010, 32'h08);
        total++;
        if (mem_rdata !== 32'h1111_8011) $display("FAIL sw_0a_drop: got %h want 11118011", mem_rdata);
        else passed++;
        load(3'b010, 32'h200);
        total++;
        if (range_err !== 1'b1 || mem_rdata !== 32'h0)
            $display("FAIL lw_200: range_err %b data %h, want 1 and 0", range_err, mem_rdata);
        else passed++;
        load(3'b010, 32'h1FC);
        total++;
        if (range_err !== 1'b0) $display("FAIL lw_1fc_range: got %b want 0", range_err);
        else passed++;
        load(3'b011, 32'h0);
        total++;
        if (misaligned !== 1'b1 || mem_rdata !== 32'h0)
            $display("FAIL f3_011: mis %b data %h, want 1 and 0", misaligned, mem_rdata);
        else passed++;
        load(3'b001, 32'h0F);
        total++;
        if (misaligned !== 1'b1) $display("FAIL lh_0f_mis: got %b want 1", misaligned);
        else passed++;
        load(3'b101, 32'h0E);
        total++;
        if (misaligned !== 1'b0) $display("FAIL lhu_0e_mis: got %b want 0", misaligned);
        else passed++;
        idle();
        repeat (5) step();
        total++;
        if (err_sticky !== 1'b1) $display("FAIL sticky_hold: got %b want 1", err_sticky);
        else passed++;
    endtask

    task automatic test_reset_mid_clear();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (60) step();
        rst = 1'b1;
        step();
        total++;
        if (busy !== 1'b1 || err_sticky !== 1'b0)
            $display("FAIL mid_reset: busy %b sticky %b, want 1 and 0", busy, err_sticky);
        else passed++;
        rst = 1'b0;
        count_clear("mid_clear_latency");
        load(3'b010, 32'h08);
        total++;
        if (mem_rdata !== 32'h0) $display("FAIL mid_clear_zero: got %h want 0", mem_rdata);
        else passed++;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_clear();
        test_word();
        test_back_to_back();
        test_byte();
        test_half();
        test_faults();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
